accel_chan_scheduler: RTL and testbench

Time-shares the single accelerometer time-processing datapath between NCHAN accelerometer channels. Computer-side read requests are granted in round-robin order. For each grant the block selects the channel, lets the select lines settle, clears the shared counter, gates counting for a fixed window, latches the result and acknowledges the requester. All sequencing is paced by the bit-time phase strobe; HLT freezes the sequence.

---
 rtl/accel_chan_scheduler.sv | 154 +++++++++++++++
 tb/tb_accel_chan_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_chan_scheduler.sv
// accel_chan_scheduler
// Shares one accelerometer time-processing datapath between NCHAN channels.
// Read requests are granted round-robin. For each grant the block selects the
// channel, waits for the select lines to settle, clears the shared counter,
// gates counting for a fixed window, latches the result and acknowledges the
// requester. Every state change is paced by the PHS bit-time strobe, and HLT
// freezes the whole sequence.
//
// Ports:
//   SIM_CLK  in   system clock
//   SIM_RST  in   synchronous active-low reset
//   PHS      in   one-clock bit-time strobe; qualifies every state change
//   HLT      in   halt; PHS is ignored and all state holds while high
//   REQ      in   per-channel read request level, held until its ACK
//   ACC_CNT  in   shared processor counter value
//   SEL      out  one-hot channel select, 0 when idle
//   CLR      out  counter clear to the processor
//   GATE     out  count enable to the processor
//   DATA     out  last latched counter value
//   ACK      out  one-hot, one-clock completion pulse to the granted channel
//   BUSY     out  high whenever a sequence is in progress
//
// state  | meaning
// IDLE   | no grant; waits for a step with any REQ set
// SETTLE | channel selected, select lines settling for SETTLE steps
// CLEAR  | CLR asserted for one step interval
// COUNT  | GATE asserted for WINDOW step intervals
// LATCH  | next step captures ACC_CNT into DATA and pulses ACK

module accel_chan_scheduler #(
  parameter int NCHAN  = 4,
  parameter int CNT_W  = 8,
  parameter int SETTLE = 2,
  parameter int WINDOW = 4
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic             PHS,
  input  logic             HLT,
  input  logic [NCHAN-1:0] REQ,
  input  logic [CNT_W-1:0] ACC_CNT,
  output logic [NCHAN-1:0] SEL,
  output logic             CLR,
  output logic             GATE,
  output logic [CNT_W-1:0] DATA,
  output logic [NCHAN-1:0] ACK,
  output logic             BUSY
);

  localparam int PTR_W = $clog2(NCHAN);
  localparam int MAXC  = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int CW    = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_COUNT  = 3'd3;
  localparam logic [2:0] S_LATCH  = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gidx;
  logic             step;
  logic             found;
  logic [PTR_W-1:0] grant_idx;

  assign step = PHS & ~HLT;

  // Round-robin search: first requester at or above ptr, wrapping to 0.
  always_comb begin
    logic [PTR_W-1:0] idx;
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int i = 0; i < NCHAN; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NCHAN);
      if (!found && REQ[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      ptr   <= '0;
      gidx  <= '0;
      SEL   <= '0;
      CLR   <= 1'b0;
      GATE  <= 1'b0;
      DATA  <= '0;
      ACK   <= '0;
      BUSY  <= 1'b0;
    end else begin
      // ACK is a single-clock pulse; it drops whether or not a step occurs.
      ACK <= '0;
      if (step) begin
        case (state)
          S_IDLE: begin
            if (found) begin
              SEL   <= NCHAN'(1) << grant_idx;
              gidx  <= grant_idx;
              cnt   <= '0;
              BUSY  <= 1'b1;
              state <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (cnt == CW'(SETTLE - 1)) begin
              CLR   <= 1'b1;
              state <= S_CLEAR;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_CLEAR: begin
            // CLR and GATE swap on the same edge so they never overlap.
            cnt   <= '0;
            CLR   <= 1'b0;
            GATE  <= 1'b1;
            state <= S_COUNT;
          end
          S_COUNT: begin
            if (cnt == CW'(WINDOW - 1)) begin
              GATE  <= 1'b0;
              state <= S_LATCH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_LATCH: begin
            DATA  <= ACC_CNT;
            ACK   <= SEL;
            ptr   <= (gidx == PTR_W'(NCHAN - 1)) ? '0 : gidx + 1'b1;
            SEL   <= '0;
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            SEL   <= '0;
            CLR   <= 1'b0;
            GATE  <= 1'b0;
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_accel_chan_scheduler.sv
module tb_accel_chan_scheduler;

  localparam int NCHAN  = 4;
  localparam int CNT_W  = 8;
  localparam int SETTLE = 2;
  localparam int WINDOW = 4;
  localparam int LAT    = SETTLE + WINDOW + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             phs;
  logic             hlt;
  logic [NCHAN-1:0] req;
  logic [CNT_W-1:0] acc;
  logic [NCHAN-1:0] sel;
  logic             clr;
  logic             gate;
  logic [CNT_W-1:0] data;
  logic [NCHAN-1:0] ack;
  logic             busy;

  always #5 clk = ~clk;

  accel_chan_scheduler #(
    .NCHAN(NCHAN), .CNT_W(CNT_W), .SETTLE(SETTLE), .WINDOW(WINDOW)
  ) dut (
    .SIM_CLK(clk), .SIM_RST(rst_n), .PHS(phs), .HLT(hlt), .REQ(req),
    .ACC_CNT(acc), .SEL(sel), .CLR(clr), .GATE(gate), .DATA(data),
    .ACK(ack), .BUSY(busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a sequence is "p steps since grant"; outputs follow
  // from p alone, and the capture happens on step LAT after the grant.
  bit               m_busy = 0;
  int               m_g = 0;
  int               m_p = 0;
  int               m_ptr = 0;
  logic [CNT_W-1:0] m_data = '0;
  logic [NCHAN-1:0] m_ack = '0;
  logic [NCHAN-1:0] exp_sel;
  logic             exp_clr;
  logic             exp_gate;

  int               phsno = 0;
  int               grant_ph = 0;
  int               ack_total = 0;
  int               ack_ph[$];
  int               ack_ch[$];
  logic [NCHAN-1:0] prev_sel = '0;

  always @(posedge clk) begin
    if (phs) phsno++;
    if (!rst_n) begin
      m_busy = 0; m_ptr = 0; m_p = 0; m_data = '0; m_ack = '0;
    end else begin
      m_ack = '0;
      if (phs && !hlt) begin
        if (!m_busy) begin
          for (int i = 0; i < NCHAN; i++) begin
            int idx;
            idx = (m_ptr + i) % NCHAN;
            if (!m_busy && req[idx]) begin
              m_busy = 1; m_g = idx; m_p = 0;
            end
          end
        end else begin
          m_p++;
          if (m_p == LAT) begin
            m_data = acc;
            m_ack  = NCHAN'(1 << m_g);
            m_busy = 0;
            m_ptr  = (m_g + 1) % NCHAN;
          end
        end
      end
    end
    #1;
    exp_sel  = m_busy ? NCHAN'(1 << m_g) : '0;
    exp_clr  = m_busy && (m_p == SETTLE);
    exp_gate = m_busy && (m_p >= SETTLE + 1) && (m_p <= SETTLE + WINDOW);
    chk("sel",  32'(sel),  32'(exp_sel));
    chk("clr",  32'(clr),  32'(exp_clr));
    chk("gate", 32'(gate), 32'(exp_gate));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ack",  32'(ack),  32'(m_ack));
    chk("data", 32'(data), 32'(m_data));
    if (sel != '0 && prev_sel == '0) grant_ph = phsno;
    if (ack != '0) begin
      int ch;
      ch = -1;
      for (int i = 0; i < NCHAN; i++) if (ack[i]) ch = i;
      ack_total++;
      ack_ph.push_back(phsno);
      ack_ch.push_back(ch);
    end
    prev_sel = sel;
  end

  bit acc_fixed = 0;

  // One clock; the requester side drops its REQ bit when it sees its ACK.
  task automatic clk_n();
    @(negedge clk);
    if (!acc_fixed) acc = CNT_W'($urandom);
    req = req & ~ack;
  endtask

  task automatic pulse(input int gap);
    phs = 1'b1;
    clk_n();
    phs = 1'b0;
    repeat (gap - 1) clk_n();
  endtask

  task automatic until_acks(input int n, input int max_pulses, input string name);
    int start;
    int k;
    start = ack_total;
    k = 0;
    while ((ack_total - start) < n && k < max_pulses) begin
      pulse(4);
      k++;
    end
    chk({name, "_ack_seen"}, 32'(ack_total - start), 32'(n));
  endtask

  task automatic until_gate(input int max_pulses, input string name);
    int k;
    k = 0;
    while (gate !== 1'b1 && k < max_pulses) begin
      pulse(4);
      k++;
    end
    chk({name, "_gate_seen"}, 32'(gate), 32'd1);
  endtask

  initial begin
    int pre;
    rst_n = 1'b0; phs = 1'b0; hlt = 1'b0; req = '0; acc = '0;
    repeat (3) clk_n();
    chk("rst_sel",  32'(sel),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    rst_n = 1'b1;
    clk_n();

    // Single request, ACK 8 steps after grant, fixed capture value.
    acc_fixed = 1; acc = 8'h5A; req = 4'b0001;
    until_acks(1, 12, "t1");
    chk("t1_latency", 32'(ack_ph[$] - grant_ph), 32'd8);
    chk("t1_data",    32'(data),   32'h5A);
    chk("t1_model_data", 32'(m_data), 32'h5A);
    pulse(4);
    chk("t1_busy_after", 32'(busy), 32'd0);
    acc_fixed = 0;

    // All channels requesting from ptr=0: order 0..3, 9 steps apart.
    rst_n = 1'b0; clk_n(); rst_n = 1'b1; clk_n();
    ack_ph.delete(); ack_ch.delete();
    req = 4'b1111;
    until_acks(4, 50, "t2");
    if (ack_ch.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t2_order", 32'(ack_ch[i]), 32'(i));
      for (int i = 1; i < 4; i++) chk("t2_spacing", 32'(ack_ph[i] - ack_ph[i-1]), 32'd9);
    end
    chk("t2_model_ptr_wrap", 32'(m_ptr), 32'd0);

    // After serving ch2, ptr=3: ch3 before ch0.
    req = 4'b0100;
    until_acks(1, 20, "t3a");
    ack_ch.delete(); ack_ph.delete();
    req = 4'b1001;
    until_acks(2, 30, "t3");
    if (ack_ch.size() == 2) begin
      chk("t3_first",  32'(ack_ch[0]), 32'd3);
      chk("t3_second", 32'(ack_ch[1]), 32'd0);
    end

    // Halt for 5 PHS during COUNT with cnt=1: ACK late by exactly 5.
    req = 4'b0001;
    until_gate(10, "t4");
    pulse(4);
    hlt = 1'b1;
    repeat (5) pulse(4);
    chk("t4_gate_held", 32'(gate), 32'd1);
    hlt = 1'b0;
    until_acks(1, 20, "t4");
    chk("t4_latency", 32'(ack_ph[$] - grant_ph), 32'd13);

    // Reset mid-COUNT: everything clears, no ACK, ch0 regranted.
    req = 4'b0001;
    until_gate(10, "t5");
    pre = ack_total;
    rst_n = 1'b0;
    clk_n();
    rst_n = 1'b1;
    chk("t5_sel",  32'(sel),  32'd0);
    chk("t5_gate", 32'(gate), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ack",  32'(ack),  32'd0);
    pulse(4);
    chk("t5_regrant", 32'(sel), 32'b0001);
    chk("t5_no_ack", 32'(ack_total - pre), 32'd0);
    until_acks(1, 20, "t5");

    // Granted REQ dropped during SETTLE: sequence still completes once.
    req = 4'b0010;
    pulse(4);
    chk("t6_granted", 32'(sel), 32'b0010);
    pulse(4);
    req = '0;
    pre = ack_total;
    repeat (12) pulse(4);
    chk("t6_ack_once", 32'(ack_total - pre), 32'd1);
    if (ack_ch.size() > 0) chk("t6_ack_ch", 32'(ack_ch[$]), 32'd1);

    // Random traffic, halts, back-to-back strobes and rare resets.
    for (int c = 0; c < 4000; c++) begin
      clk_n();
      phs   = ($urandom_range(0, 2) == 0);
      hlt   = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 5) == 0) req = req | NCHAN'(1 << $urandom_range(0, NCHAN - 1));
    end
    phs = 1'b0; hlt = 1'b0; rst_n = 1'b1;
    clk_n();
    clk_n();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
